// File: rtl/bcd_updown_counter.sv
// Multi-decade BCD up/down counter with pushbutton step synchroniser,
// BCD preset load, roll-over pulse and seven-segment decode.
module bcd_updown_counter #(
   parameter int DIGITS         = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit BLANK_LZ       = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  step,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   hex,
   output logic                  wrap
);

   logic                r_sync1, r_sync2, r_hist;
   logic [4*DIGITS-1:0] r_bcd;
   logic                r_wrap;

   logic                w_pulse;
   logic [4*DIGITS-1:0] w_next;
   logic [4*DIGITS-1:0] w_load;
   logic                w_ripple;
   logic [7*DIGITS-1:0] w_hex;
   logic                w_lz;
   logic [6:0]          w_seg;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b0111111;
         4'd1:    seg7 = 7'b0000110;
         4'd2:    seg7 = 7'b1011011;
         4'd3:    seg7 = 7'b1001111;
         4'd4:    seg7 = 7'b1100110;
         4'd5:    seg7 = 7'b1101101;
         4'd6:    seg7 = 7'b1111101;
         4'd7:    seg7 = 7'b0000111;
         4'd8:    seg7 = 7'b1111111;
         4'd9:    seg7 = 7'b1101111;
         default: seg7 = 7'b0000000;
      endcase
   endfunction

   assign w_pulse = r_sync2 & ~r_hist;

   // Ripple carry/borrow across decades; w_ripple left high means a full wrap.
   // NOTE: always_comb uses blocking assignments so each decade sees the
   // ripple value produced by the one below it within the same pass.
   always_comb begin
      w_next   = r_bcd;
      w_ripple = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_ripple) begin
            if (up) begin
               if (r_bcd[4*i +: 4] == 4'd9) begin
                  w_next[4*i +: 4] = 4'd0;
               end else begin
                  w_next[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
                  w_ripple         = 1'b0;
               end
            end else begin
               if (r_bcd[4*i +: 4] == 4'd0) begin
                  w_next[4*i +: 4] = 4'd9;
               end else begin
                  w_next[4*i +: 4] = r_bcd[4*i +: 4] - 4'd1;
                  w_ripple         = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      w_load = load_val;
      for (int i = 0; i < DIGITS; i++) begin
         if (load_val[4*i +: 4] > 4'd9) w_load[4*i +: 4] = 4'd9;
      end
   end

   // NOTE: the synchroniser and history flops reset to 1, so a button held
   // through reset release looks like "already seen" and cannot count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_hist  <= 1'b1;
         r_bcd   <= '0;
         r_wrap  <= 1'b0;
      end else begin
         r_sync1 <= step;
         r_sync2 <= r_sync1;
         r_hist  <= r_sync2;
         r_wrap  <= 1'b0;
         if (load) begin
            r_bcd <= w_load;
         end else if (w_pulse) begin
            r_bcd  <= w_next;
            r_wrap <= w_ripple;
         end
      end
   end

   // Walk from the top decade down so w_lz means "this and all higher are 0".
   always_comb begin
      w_hex = '0;
      w_lz  = 1'b1;
      w_seg = 7'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         w_lz  = w_lz & (r_bcd[4*i +: 4] == 4'd0);
         w_seg = (BLANK_LZ && (i > 0) && w_lz) ? 7'b0000000 : seg7(r_bcd[4*i +: 4]);
         w_hex[7*i +: 7] = SEG_ACTIVE_LOW ? ~w_seg : w_seg;
      end
   end

   assign bcd  = r_bcd;
   assign wrap = r_wrap;
   assign hex  = w_hex;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: vector table plus hand-written
// sequences for step timing, load/pulse collision, reset and blanking.
module tb_bcd_updown_counter;

   logic        clk = 1'b0;
   logic        rst;
   logic        step, up, load;
   logic [7:0]  load_val;
   logic [7:0]  bcd;
   logic [13:0] hex;
   logic        wrap;

   logic        load3;
   logic [11:0] load_val3;
   logic [11:0] bcd3;
   logic [20:0] hex3;
   logic        wrap3;
   logic        step3, up3;

   int checks   = 0;
   int failures = 0;

   bcd_updown_counter dut (
      .clk(clk), .rst(rst), .step(step), .up(up), .load(load),
      .load_val(load_val), .bcd(bcd), .hex(hex), .wrap(wrap)
   );

   bcd_updown_counter #(.DIGITS(3), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut3 (
      .clk(clk), .rst(rst), .step(step3), .up(up3), .load(load3),
      .load_val(load_val3), .bcd(bcd3), .hex(hex3), .wrap(wrap3)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] seg_ah(input logic [3:0] d);
      case (d)
         4'd0:    seg_ah = 7'b0111111;
         4'd1:    seg_ah = 7'b0000110;
         4'd2:    seg_ah = 7'b1011011;
         4'd3:    seg_ah = 7'b1001111;
         4'd4:    seg_ah = 7'b1100110;
         4'd5:    seg_ah = 7'b1101101;
         4'd6:    seg_ah = 7'b1111101;
         4'd7:    seg_ah = 7'b0000111;
         4'd8:    seg_ah = 7'b1111111;
         4'd9:    seg_ah = 7'b1101111;
         default: seg_ah = 7'b0000000;
      endcase
   endfunction

   function automatic logic [13:0] exp_hex(input logic [7:0] b);
      return ~{seg_ah(b[7:4]), seg_ah(b[3:0])};
   endfunction

   task automatic do_load(input logic [7:0] v, output int wraps);
      @(negedge clk);
      load     = 1'b1;
      load_val = v;
      @(negedge clk);
      load  = 1'b0;
      wraps = int'(wrap);
   endtask

   // Hold step for six cycles then release; counts every cycle wrap is seen.
   task automatic do_press(input logic dir, output int wraps);
      @(negedge clk);
      up    = dir;
      step  = 1'b1;
      wraps = 0;
      repeat (6) begin
         @(negedge clk);
         if (wrap) wraps++;
      end
      step = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (wrap) wraps++;
      end
   endtask

   task automatic load3_val(input logic [11:0] v);
      @(negedge clk);
      load3     = 1'b1;
      load_val3 = v;
      @(negedge clk);
      load3 = 1'b0;
   endtask

   typedef struct {
      bit         is_load;
      logic       dir;
      logic [7:0] val;
      logic [7:0] exp_bcd;
      int         exp_wraps;
   } vec_t;

   vec_t vecs[13];

   initial begin
      int wr;

      vecs[0]  = '{1'b1, 1'b1, 8'h99, 8'h99, 0};
      vecs[1]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1};
      vecs[2]  = '{1'b0, 1'b0, 8'h00, 8'h99, 1};
      vecs[3]  = '{1'b1, 1'b1, 8'h10, 8'h10, 0};
      vecs[4]  = '{1'b0, 1'b0, 8'h00, 8'h09, 0};
      vecs[5]  = '{1'b0, 1'b1, 8'h00, 8'h10, 0};
      vecs[6]  = '{1'b1, 1'b1, 8'hAF, 8'h99, 0};
      vecs[7]  = '{1'b1, 1'b1, 8'h3C, 8'h39, 0};
      vecs[8]  = '{1'b0, 1'b1, 8'h00, 8'h40, 0};
      vecs[9]  = '{1'b0, 1'b0, 8'h00, 8'h39, 0};
      vecs[10] = '{1'b0, 1'b0, 8'h00, 8'h38, 0};
      vecs[11] = '{1'b1, 1'b1, 8'h50, 8'h50, 0};
      vecs[12] = '{1'b0, 1'b0, 8'h00, 8'h49, 0};

      rst = 1'b1; step = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
      load3 = 1'b0; load_val3 = '0; step3 = 1'b0; up3 = 1'b1;

      // Reset state before any clock edge
      #2;
      check("rst_bcd", bcd, 8'h00);
      check("rst_hex", hex, 14'b1000000_1000000);
      check("rst_wrap", wrap, 1'b0);
      check("rst_hex3_blank", hex3, {7'b1111111, 7'b1111111, 7'b1000000});
      @(negedge clk);
      rst = 1'b0;

      // Step latency: sampled at edge N, count at N+2, held step counts once
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      check("lat_edgeN", bcd, 8'h00);
      @(negedge clk);
      check("lat_edgeN1", bcd, 8'h00);
      @(negedge clk);
      check("lat_edgeN2", bcd, 8'h01);
      repeat (17) @(negedge clk);
      check("held_step_once", bcd, 8'h01);
      step = 1'b0;
      @(negedge clk);
      for (int p = 0; p < 9; p++) do_press(1'b1, wr);
      check("ten_presses", bcd, 8'h10);

      for (int i = 0; i < 13; i++) begin
         if (vecs[i].is_load) do_load(vecs[i].val, wr);
         else                 do_press(vecs[i].dir, wr);
         check($sformatf("vec%0d_bcd", i), bcd, vecs[i].exp_bcd);
         check($sformatf("vec%0d_hex", i), hex, exp_hex(vecs[i].exp_bcd));
         check($sformatf("vec%0d_wraps", i), wr, vecs[i].exp_wraps);
      end

      // Load collides with a count pulse: load wins, pulse is dropped
      @(negedge clk);
      up   = 1'b1;
      step = 1'b1;
      @(negedge clk);
      @(negedge clk);
      load     = 1'b1;
      load_val = 8'h3C;
      @(negedge clk);
      load = 1'b0;
      check("collide_bcd", bcd, 8'h39);
      check("collide_wrap", wrap, 1'b0);
      wr = 0;
      repeat (4) begin
         @(negedge clk);
         if (wrap) wr++;
      end
      check("collide_not_deferred", bcd, 8'h39);
      check("collide_no_wrap", wr, 0);
      step = 1'b0;
      @(negedge clk);

      // Asynchronous reset between clock edges
      do_load(8'h57, wr);
      check("pre_rst_57", bcd, 8'h57);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_bcd", bcd, 8'h00);
      check("async_rst_hex", hex, 14'b1000000_1000000);
      check("async_rst_wrap", wrap, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Step held across reset with a pulse in flight: no count afterwards
      do_load(8'h00, wr);
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("step_through_rst", bcd, 8'h00);
      step = 1'b0;
      @(negedge clk);
      do_press(1'b1, wr);
      check("repress_after_rst", bcd, 8'h01);

      // Leading-zero blanking on the three-decade instance
      load3_val(12'h005);
      check("lz_bcd3", bcd3, 12'h005);
      check("lz_005", hex3, {7'b1111111, 7'b1111111, 7'b0010010});
      load3_val(12'h105);
      check("lz_105", hex3, {7'b1111001, 7'b1000000, 7'b0010010});
      load3_val(12'h0A0);
      check("lz_090", hex3, {7'b1111111, 7'b0010000, 7'b1000000});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS, default 2, number of BCD decades (1..8).
REQ-002 Parameter SEG_ACTIVE_LOW, default 1; 1 = segment on drives 0, 0 = segment on drives 1.
REQ-003 Parameter BLANK_LZ, default 0; 1 = blank leading-zero digits.
REQ-004 clk  input  1  single system clock, rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 step  input  1  asynchronous count request (pushbutton level); one count per rising edge.
REQ-007 up  input  1  direction: 1 = increment, 0 = decrement; sampled in the cycle the count is applied.
REQ-008 load  input  1  synchronous load strobe, clk-domain.
REQ-009 load_val  input  4*DIGITS  BCD preset; digit i at [4i+3:4i].
REQ-010 bcd  output  4*DIGITS  registered count; digit i at [4i+3:4i], digit 0 least significant.
REQ-011 hex  output  7*DIGITS  seven-segment drive; digit i at [7i+6:7i], bit order a(0)..g(6).
REQ-012 wrap  output  1  one-cycle registered pulse on roll-over or roll-under.

Function
REQ-013 step SHALL pass through a 2-flop synchroniser plus one edge-history flop; count pulse = sync2 & ~hist.
REQ-014 If step is first sampled 1 at edge N, bcd SHALL change at edge N+2; holding step high SHALL produce exactly one count.
REQ-015 Increment: digit 0 +1; a digit at 9 SHALL become 0 and carry into the next digit; carry ripples combinationally within one cycle.
REQ-016 Decrement: digit 0 -1; a digit at 0 SHALL become 9 and borrow from the next digit.
REQ-017 Up from all-9s SHALL give all-0s; down from all-0s SHALL give all-9s; wrap SHALL be 1 for exactly the cycle after that edge.
REQ-018 wrap SHALL be 0 in every other cycle, including loads.
REQ-019 load=1 at an edge SHALL copy load_val into bcd at that edge; any load_val digit 10..15 SHALL load as 9.
REQ-020 load and a count pulse at the same edge: load wins, the pulse is discarded (not deferred).
REQ-021 bcd SHALL only ever hold digits 0..9.
REQ-022 hex SHALL be combinational from bcd; active-high patterns gfedcba: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111; inverted when SEG_ACTIVE_LOW=1.
REQ-023 BLANK_LZ=1: digit i>0 SHALL be blank (all segments off) when it and every higher digit are 0; digit 0 is never blanked.
REQ-024 Direction change between pulses SHALL take effect on the next pulse with no extra latency.

Reset
REQ-025 rst=1 SHALL immediately, without clk, force bcd=0, wrap=0, hex to "0" on every digit (or blank per REQ-023).
REQ-026 Synchroniser and history flops SHALL reset to 1, so step held high across reset release produces no count.
REQ-027 rst asserted mid-operation SHALL discard any in-flight pulse; counting resumes only after a new step rising edge following release.

Verification
REQ-028 Count 57, assert rst asynchronously -> bcd=8'h00, hex=14'b1000000_1000000, wrap=0 before the next clk edge.
REQ-029 bcd=00, up=1, step high from edge N held 20 cycles -> bcd=01 at edge N+2, unchanged thereafter; repeat 10 presses -> bcd=10.
REQ-030 load_val=8'h99 loaded, up=1, one press -> bcd=00, wrap high exactly one cycle; up=0 at 00, one press -> 99, wrap pulse; from 10, down -> 09.
REQ-031 load=1, load_val=8'h3C in the same cycle as a count pulse -> bcd=39, no increment, wrap=0.
REQ-032 step held 1 through rst assertion and release -> bcd stays 00; release and re-press step -> bcd=01.
REQ-033 DIGITS=3, BLANK_LZ=1, bcd=005 -> digits 2 and 1 all-off (1111111 active-low), digit 0 shows 5 (0010010).
